// File: rtl/snitch_perf_cnt_alloc.sv
// Performance-counter pool allocator: round-robin hart arbitration, lowest-free
// counter selection and one in-flight configuration write to the counter block.
module snitch_perf_cnt_alloc #(
  parameter int unsigned NrCores         = 8,
  parameter int unsigned NumPerfCounters = 16,
  parameter int unsigned MetricWidth     = 5,
  localparam int unsigned IdxW  = (NumPerfCounters > 1) ? $clog2(NumPerfCounters) : 1,
  localparam int unsigned HartW = (NrCores > 1) ? $clog2(NrCores) : 1,
  localparam int unsigned CntW  = $clog2(NumPerfCounters + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrCores-1:0]                  alloc_valid_i,
  input  logic [NrCores-1:0][MetricWidth-1:0] alloc_metric_i,
  output logic [NrCores-1:0]                  alloc_ready_o,
  output logic [IdxW-1:0]                     alloc_idx_o,
  input  logic [NrCores-1:0]                  release_valid_i,
  input  logic [NrCores-1:0][IdxW-1:0]        release_idx_i,
  output logic [NrCores-1:0]                  release_ready_o,
  output logic                                release_err_o,
  output logic                                cfg_valid_o,
  input  logic                                cfg_ready_i,
  output logic [IdxW-1:0]                     cfg_idx_o,
  output logic [MetricWidth-1:0]              cfg_metric_o,
  output logic [HartW-1:0]                    cfg_hart_o,
  output logic                                cfg_en_o,
  output logic                                cfg_clr_o,
  output logic [NumPerfCounters-1:0]          busy_o,
  output logic [CntW-1:0]                     free_cnt_o,
  output logic                                full_o
);

  typedef enum logic [1:0] {IDLE, CFG, ACK} state_e;

  state_e                                state_q, state_d;
  logic [NumPerfCounters-1:0]            busy_q, busy_d;
  logic [NumPerfCounters-1:0][HartW-1:0] owner_q, owner_d;
  logic [HartW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                                  is_alloc_q, is_alloc_d;
  logic [CntW-1:0]                       free_cnt_q, free_cnt_d;
  logic                                  full_q, full_d;
  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [MetricWidth-1:0]                metric_q, metric_d;
  logic [HartW-1:0]                      hart_q, hart_d;

  // Pool views padded to the full index range so any release index is safe to look up.
  logic [(2**IdxW)-1:0]                  busy_ext;
  logic [(2**IdxW)-1:0][HartW-1:0]       owner_ext;

  logic             rel_found, rel_ok;
  logic [HartW-1:0] rel_hart;
  logic [IdxW-1:0]  rel_idx;
  logic             alloc_found;
  logic [HartW-1:0] alloc_hart;
  logic [IdxW-1:0]  free_idx;

  always_comb begin : arbitrate
    int unsigned k;
    k         = 0;
    busy_ext  = '0;
    owner_ext = '0;
    busy_ext[NumPerfCounters-1:0]  = busy_q;
    owner_ext[NumPerfCounters-1:0] = owner_q;

    rel_found = 1'b0;
    rel_hart  = '0;
    for (int h = int'(NrCores) - 1; h >= 0; h--) begin
      if (release_valid_i[h]) begin
        rel_found = 1'b1;
        rel_hart  = HartW'(h);
      end
    end
    rel_idx = release_idx_i[rel_hart];
    rel_ok  = rel_found && busy_ext[rel_idx] && (owner_ext[rel_idx] == rel_hart);

    alloc_found = 1'b0;
    alloc_hart  = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      k = 32'(rr_ptr_q) + i;
      if (k >= NrCores) k = k - NrCores;
      if (!alloc_found && alloc_valid_i[HartW'(k)]) begin
        alloc_found = 1'b1;
        alloc_hart  = HartW'(k);
      end
    end

    free_idx = '0;
    for (int i = int'(NumPerfCounters) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
    end
  end

  always_comb begin : fsm
    state_d         = state_q;
    busy_d          = busy_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    is_alloc_d      = is_alloc_q;
    idx_d           = idx_q;
    metric_d        = metric_q;
    hart_d          = hart_q;
    release_ready_o = '0;
    release_err_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rel_found) begin
          release_ready_o[rel_hart] = 1'b1;
          if (rel_ok) begin
            busy_d[rel_idx] = 1'b0;
            idx_d           = rel_idx;
            is_alloc_d      = 1'b0;
            state_d         = CFG;
          end else begin
            release_err_o = 1'b1;
          end
        end else if (alloc_found && !full_q) begin
          idx_d             = free_idx;
          metric_d          = alloc_metric_i[alloc_hart];
          hart_d            = alloc_hart;
          is_alloc_d        = 1'b1;
          busy_d[free_idx]  = 1'b1;
          owner_d[free_idx] = alloc_hart;
          state_d           = CFG;
        end
      end
      CFG: begin
        if (cfg_ready_i) state_d = is_alloc_q ? ACK : IDLE;
      end
      ACK: begin
        rr_ptr_d = (32'(hart_q) == NrCores - 1) ? '0 : hart_q + HartW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    full_d     = &busy_d;
    free_cnt_d = '0;
    for (int unsigned i = 0; i < NumPerfCounters; i++) begin
      if (!busy_d[i]) free_cnt_d = free_cnt_d + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      is_alloc_q <= 1'b0;
      free_cnt_q <= CntW'(NumPerfCounters);
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      is_alloc_q <= is_alloc_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= full_d;
    end
  end

  // Payload is only observed through the state-gated outputs below, so it carries no reset.
  always_ff @(posedge clk_i) begin
    idx_q    <= idx_d;
    metric_q <= metric_d;
    hart_q   <= hart_d;
  end

  always_comb begin : ack_out
    alloc_ready_o = '0;
    if (state_q == ACK) alloc_ready_o[hart_q] = 1'b1;
  end

  assign alloc_idx_o  = (state_q == ACK) ? idx_q : '0;
  assign cfg_valid_o  = (state_q == CFG);
  assign cfg_idx_o    = cfg_valid_o ? idx_q : '0;
  assign cfg_metric_o = (cfg_valid_o && is_alloc_q) ? metric_q : '0;
  assign cfg_hart_o   = (cfg_valid_o && is_alloc_q) ? hart_q : '0;
  assign cfg_en_o     = cfg_valid_o && is_alloc_q;
  assign cfg_clr_o    = cfg_valid_o && is_alloc_q;
  assign busy_o       = busy_q;
  assign free_cnt_o   = free_cnt_q;
  assign full_o       = full_q;

endmodule

// File: tb/tb_snitch_perf_cnt_alloc.sv
// Self-checking bench for snitch_perf_cnt_alloc: table of single alloc/release
// operations plus arbitration, pool-full, backpressure and reset sequences.
module tb_snitch_perf_cnt_alloc;
  localparam int NrCores         = 8;
  localparam int NumPerfCounters = 16;
  localparam int MetricWidth     = 5;
  localparam int IdxW            = 4;
  localparam int HartW           = 3;
  localparam int CntW            = 5;

  logic                                clk = 1'b0;
  logic                                rst_i = 1'b1;
  logic [NrCores-1:0]                  alloc_valid = '0;
  logic [NrCores-1:0][MetricWidth-1:0] alloc_metric = '0;
  logic [NrCores-1:0]                  alloc_ready_o;
  logic [IdxW-1:0]                     alloc_idx_o;
  logic [NrCores-1:0]                  release_valid = '0;
  logic [NrCores-1:0][IdxW-1:0]        release_idx = '0;
  logic [NrCores-1:0]                  release_ready_o;
  logic                                release_err_o;
  logic                                cfg_valid_o;
  logic                                cfg_ready = 1'b1;
  logic [IdxW-1:0]                     cfg_idx_o;
  logic [MetricWidth-1:0]              cfg_metric_o;
  logic [HartW-1:0]                    cfg_hart_o;
  logic                                cfg_en_o;
  logic                                cfg_clr_o;
  logic [NumPerfCounters-1:0]          busy_o;
  logic [CntW-1:0]                     free_cnt_o;
  logic                                full_o;

  always #5 clk = ~clk;

  snitch_perf_cnt_alloc #(
    .NrCores(NrCores), .NumPerfCounters(NumPerfCounters), .MetricWidth(MetricWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid), .alloc_metric_i(alloc_metric),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .release_valid_i(release_valid), .release_idx_i(release_idx),
    .release_ready_o(release_ready_o), .release_err_o(release_err_o),
    .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready),
    .cfg_idx_o(cfg_idx_o), .cfg_metric_o(cfg_metric_o), .cfg_hart_o(cfg_hart_o),
    .cfg_en_o(cfg_en_o), .cfg_clr_o(cfg_clr_o),
    .busy_o(busy_o), .free_cnt_o(free_cnt_o), .full_o(full_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int hart; int idx; } exp_t;
  exp_t sb[$];

  typedef struct {
    bit is_rel;
    int hart;
    int val;       // metric for an allocation, counter index for a release
    int exp_idx;
    bit exp_err;
    int exp_busy;
  } vec_t;
  vec_t tbl[10];

  // A requester may only drop its request once the grant has been seen.
  logic [NrCores-1:0] prev_pend = '0;
  logic               prev_rst  = 1'b1;
  always @(posedge clk) begin
    for (int h = 0; h < NrCores; h++)
      if (prev_pend[h] && !prev_rst && !rst_i)
        assert (alloc_valid[h] || alloc_ready_o[h])
          else $error("alloc request on hart %0d withdrawn before its grant", h);
    prev_pend <= alloc_valid & ~alloc_ready_o;
    prev_rst  <= rst_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input int h, input int idx);
    exp_t e;
    e.hart = h;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  // One clock: sample at the falling edge, score any grant, retire granted requests.
  task automatic tick();
    @(negedge clk);
    if (alloc_ready_o != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(alloc_ready_o), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_hart", 32'(alloc_ready_o), 1 << e.hart);
        check("ack_idx", 32'(alloc_idx_o), e.idx);
      end
      alloc_valid = alloc_valid & ~alloc_ready_o;
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d grants still outstanding after %0d cycles, expected 0",
               name, sb.size(), bound);
      sb.delete();
      alloc_valid = '0;
    end
  endtask

  task automatic check_pool(input string name, input int exp_busy);
    check({name, "_busy"}, 32'(busy_o), exp_busy);
    check({name, "_free"}, 32'(free_cnt_o), NumPerfCounters - $countones(exp_busy[NumPerfCounters-1:0]));
    check({name, "_full"}, 32'(full_o), (exp_busy[NumPerfCounters-1:0] == '1) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    alloc_valid   = '0;
    release_valid = '0;
    tick();
    tick();
    rst_i = 1'b0;
    sb.delete();
  endtask

  // Single allocation from IDLE with cfg_ready high: cfg at t+1, grant at t+2.
  task automatic do_alloc(input int h, input int m, input int exp_idx, input int exp_busy);
    alloc_valid[h]  = 1'b1;
    alloc_metric[h] = MetricWidth'(m);
    expect_ack(h, exp_idx);
    #1;
    check("alloc_idle_cfg", 32'(cfg_valid_o), 0);
    tick();
    check("alloc_cfg_valid", 32'(cfg_valid_o), 1);
    check("alloc_cfg_idx", 32'(cfg_idx_o), exp_idx);
    check("alloc_cfg_metric", 32'(cfg_metric_o), m);
    check("alloc_cfg_hart", 32'(cfg_hart_o), h);
    check("alloc_cfg_en_clr", {30'd0, cfg_en_o, cfg_clr_o}, 3);
    wait_drain("alloc_ack_latency", 1);
    tick();
    check_pool("alloc", exp_busy);
  endtask

  task automatic do_release(input int h, input int idx, input bit exp_err, input int exp_busy);
    release_valid[h] = 1'b1;
    release_idx[h]   = IdxW'(idx);
    #1;
    check("rel_ready", 32'(release_ready_o), 1 << h);
    check("rel_err", 32'(release_err_o), exp_err);
    tick();
    release_valid[h] = 1'b0;
    check("rel_cfg_valid", 32'(cfg_valid_o), exp_err ? 0 : 1);
    if (!exp_err) begin
      check("rel_cfg_idx", 32'(cfg_idx_o), idx);
      check("rel_cfg_payload", {cfg_metric_o, cfg_hart_o, cfg_en_o, cfg_clr_o}, 0);
    end
    check_pool("rel", exp_busy);
    #1;
    check("rel_err_pulse", 32'(release_err_o), 0);
    tick();
    check("rel_cfg_done", 32'(cfg_valid_o), 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 0, 6,  0, 1'b0, 'h0001};
    tbl[1] = '{1'b0, 3, 1,  1, 1'b0, 'h0003};
    tbl[2] = '{1'b0, 7, 31, 2, 1'b0, 'h0007};
    tbl[3] = '{1'b1, 3, 1,  0, 1'b0, 'h0005};
    tbl[4] = '{1'b0, 2, 9,  1, 1'b0, 'h0007};
    tbl[5] = '{1'b1, 2, 0,  0, 1'b1, 'h0007};
    tbl[6] = '{1'b1, 0, 5,  0, 1'b1, 'h0007};
    tbl[7] = '{1'b1, 0, 0,  0, 1'b0, 'h0006};
    tbl[8] = '{1'b1, 7, 2,  0, 1'b0, 'h0002};
    tbl[9] = '{1'b1, 2, 1,  0, 1'b0, 'h0000};

    do_reset();
    check_pool("reset", 0);
    check("reset_cfg_valid", 32'(cfg_valid_o), 0);
    check("reset_alloc_ready", 32'(alloc_ready_o), 0);
    check("reset_outputs", {alloc_idx_o, cfg_idx_o, cfg_metric_o, cfg_hart_o, cfg_en_o, cfg_clr_o}, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_rel) do_release(tbl[i].hart, tbl[i].val, tbl[i].exp_err, tbl[i].exp_busy);
      else               do_alloc(tbl[i].hart, tbl[i].val, tbl[i].exp_idx, tbl[i].exp_busy);
    end

    // Backpressure: payload must hold while cfg_ready is low, grant one cycle after handshake.
    cfg_ready       = 1'b0;
    alloc_valid[6]  = 1'b1;
    alloc_metric[6] = 5'd12;
    expect_ack(6, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_cfg_valid", 32'(cfg_valid_o), 1);
      check("bp_cfg_payload", {cfg_idx_o, cfg_metric_o, cfg_hart_o, cfg_en_o, cfg_clr_o},
            {4'd0, 5'd12, 3'd6, 2'b11});
    end
    check("bp_no_early_ack", sb.size(), 1);
    cfg_ready = 1'b1;
    tick();
    check("bp_ack_after_hs", sb.size(), 0);
    tick();

    // Round-robin arbitration.
    do_reset();
    alloc_valid  = 8'b0000_1110;
    alloc_metric[1] = 5'd1;
    alloc_metric[2] = 5'd2;
    alloc_metric[3] = 5'd3;
    expect_ack(1, 0);
    expect_ack(2, 1);
    expect_ack(3, 2);
    wait_drain("rr_round1", 12);
    alloc_valid[1]  = 1'b1;
    alloc_valid[3]  = 1'b1;
    alloc_metric[1] = 5'd4;
    alloc_metric[3] = 5'd5;
    expect_ack(1, 3);
    expect_ack(3, 4);
    wait_drain("rr_round2", 10);
    alloc_valid[2]  = 1'b1;
    alloc_valid[6]  = 1'b1;
    alloc_metric[2] = 5'd7;
    alloc_metric[6] = 5'd8;
    expect_ack(6, 5);
    expect_ack(2, 6);
    wait_drain("rr_round3", 10);
    tick();
    check_pool("rr", 'h007F);

    // Fill the pool, stall a 17th request, free one counter and let the stalled request take it.
    do_reset();
    begin
      int exp_busy = 0;
      for (int i = 0; i < NumPerfCounters; i++) begin
        exp_busy = exp_busy | (1 << i);
        do_alloc((i + 1) % NrCores, i, i, exp_busy);
      end
    end
    alloc_valid[0]  = 1'b1;
    alloc_metric[0] = 5'd17;
    expect_ack(0, 4);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("full_stall_cfg", 32'(cfg_valid_o), 0);
    end
    check("full_stall_pending", sb.size(), 1);
    do_release(5, 4, 1'b0, 'hFFEF);
    wait_drain("full_refill", 3);
    tick();
    check_pool("refill", 'hFFFF);

    // Reset while a configuration write is outstanding.
    do_reset();
    cfg_ready       = 1'b0;
    alloc_valid[4]  = 1'b1;
    alloc_metric[4] = 5'd3;
    tick();
    check("rst_mid_cfg_valid", 32'(cfg_valid_o), 1);
    check("rst_mid_busy", 32'(busy_o), 1);
    rst_i          = 1'b1;
    alloc_valid[4] = 1'b0;
    tick();
    check("rst_mid_cfg_drop", 32'(cfg_valid_o), 0);
    check_pool("rst_mid", 0);
    rst_i     = 1'b0;
    cfg_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_mid_no_ack", 32'(alloc_ready_o), 0);
      check("rst_mid_no_cfg", 32'(cfg_valid_o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
